// File: rtl/tinyalu_requester.sv
// Command requester for the TinyALU: accepts one command, drives the ALU, and returns a result or a timeout.
// Optional statistics counters are enabled with the TINYALU_REQ_STATS_EN macro.

package tinyalu_pkg;
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011
    } OPCODE_T;
endpackage

module tinyalu_requester
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  OPCODE_T    cmd_op,
    output logic [7:0] alu_A,
    output logic [7:0] alu_B,
    output OPCODE_T    alu_opcode,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic [8:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] rsp_result,
    output logic       rsp_timeout
`ifdef TINYALU_REQ_STATS_EN
    ,
    output logic [15:0] stat_cmds,
    output logic [15:0] stat_timeouts
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_waitCnt;
    logic [7:0] r_aluA;
    logic [7:0] r_aluB;
    OPCODE_T    r_aluOpcode;
    logic       r_aluStart;
    logic       r_rspValid;
    logic [8:0] r_rspResult;
    logic       r_rspTimeout;
`ifdef TINYALU_REQ_STATS_EN
    logic [15:0] r_statCmds;
    logic [15:0] r_statTimeouts;
`endif

    // In ISSUE a NOP finishes at once; otherwise alu_done takes priority over the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_waitCnt      <= '0;
            r_aluA         <= '0;
            r_aluB         <= '0;
            r_aluOpcode    <= OP_NOP;
            r_aluStart     <= 1'b0;
            r_rspValid     <= 1'b0;
            r_rspResult    <= '0;
            r_rspTimeout   <= 1'b0;
`ifdef TINYALU_REQ_STATS_EN
            r_statCmds     <= '0;
            r_statTimeouts <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_aluA      <= cmd_a;
                        r_aluB      <= cmd_b;
                        r_aluOpcode <= cmd_op;
                        r_aluStart  <= 1'b1;
                        r_waitCnt   <= '0;
                        r_state     <= ISSUE;
`ifdef TINYALU_REQ_STATS_EN
                        if (r_statCmds != 16'hFFFF) r_statCmds <= r_statCmds + 16'd1;
`endif
                    end
                end
                ISSUE: begin
                    r_waitCnt <= r_waitCnt + 8'd1;
                    if (r_aluOpcode == OP_NOP) begin
                        r_rspResult  <= '0;
                        r_rspTimeout <= 1'b0;
                        r_aluStart   <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
                    end else if (alu_done) begin
                        r_rspResult  <= alu_result;
                        r_rspTimeout <= 1'b0;
                        r_aluStart   <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_waitCnt == LP_LAST_WAIT) begin
                        r_rspResult  <= '0;
                        r_rspTimeout <= 1'b1;
                        r_aluStart   <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
`ifdef TINYALU_REQ_STATS_EN
                        if (r_statTimeouts != 16'hFFFF) r_statTimeouts <= r_statTimeouts + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign alu_A       = r_aluA;
    assign alu_B       = r_aluB;
    assign alu_opcode  = r_aluOpcode;
    assign alu_start   = r_aluStart;
    assign rsp_valid   = r_rspValid;
    assign rsp_result  = r_rspResult;
    assign rsp_timeout = r_rspTimeout;
`ifdef TINYALU_REQ_STATS_EN
    assign stat_cmds     = r_statCmds;
    assign stat_timeouts = r_statTimeouts;
`endif

endmodule

// File: tb/tb_tinyalu_requester.sv
// Directed self-checking bench for tinyalu_requester with a latency-programmable TinyALU responder.
// Build with TINYALU_REQ_STATS_EN defined to also check the statistics counters.

module tb_tinyalu_requester;
    import tinyalu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    OPCODE_T    cmd_op;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    OPCODE_T    alu_opcode;
    logic       alu_start;
    logic       alu_done;
    logic [8:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [8:0] rsp_result;
    logic       rsp_timeout;
`ifdef TINYALU_REQ_STATS_EN
    logic [15:0] stat_cmds;
    logic [15:0] stat_timeouts;
`endif

    int checks = 0;
    int errors = 0;

    // Responder: raises alu_done for one cycle after seeing alu_start on aluLat edges.
    logic aluEn = 1'b1;
    int   aluLat = 1;
    int   seenCnt = 0;

    tinyalu_requester #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .cmd_op(cmd_op),
        .alu_A(alu_A),
        .alu_B(alu_B),
        .alu_opcode(alu_opcode),
        .alu_start(alu_start),
        .alu_done(alu_done),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout)
`ifdef TINYALU_REQ_STATS_EN
        ,
        .stat_cmds(stat_cmds),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            OP_ADD:  alu_result = {1'b0, alu_A} + {1'b0, alu_B};
            OP_AND:  alu_result = {1'b0, alu_A & alu_B};
            OP_XOR:  alu_result = {1'b0, alu_A ^ alu_B};
            default: alu_result = '0;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !alu_start) begin
            seenCnt  <= 0;
            alu_done <= 1'b0;
        end else begin
            seenCnt  <= seenCnt + 1;
            alu_done <= aluEn && (seenCnt + 1 == aluLat);
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one command at a negedge and follows it until rsp_valid appears (bounded).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input OPCODE_T op,
                                 output int startCycles, output int latency,
                                 output logic [8:0] res, output logic tmo, output logic seen);
        int firstStart;
        startCycles = 0;
        latency     = -1;
        firstStart  = -1;
        res         = '0;
        tmo         = 1'b0;
        seen        = 1'b0;
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_op      = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (alu_start) begin
                startCycles++;
                if (firstStart < 0) firstStart = i;
            end
            if (rsp_valid) begin
                seen    = 1'b1;
                res     = rsp_result;
                tmo     = rsp_timeout;
                latency = i - firstStart;
                break;
            end
            @(negedge clk);
        end
    endtask

    int         startCycles;
    int         latency;
    logic [8:0] res;
    logic       tmo;
    logic       seen;
    logic       quiet;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = OP_NOP;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        checkOutput("rst_alu_start", 16'(alu_start), 16'd0);
        checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        checkOutput("rst_rsp_timeout", 16'(rsp_timeout), 16'd0);
        checkOutput("rst_alu_A", 16'(alu_A), 16'd0);
        checkOutput("rst_alu_B", 16'(alu_B), 16'd0);
        checkOutput("rst_alu_opcode", 16'(alu_opcode), 16'(OP_NOP));
        checkOutput("rst_rsp_result", 16'(rsp_result), 16'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD FF+01 with rsp_ready held low for 5 cycles after the response.
        applyStimulus(8'hFF, 8'h01, OP_ADD, startCycles, latency, res, tmo, seen);
        checkOutput("add_seen", 16'(seen), 16'd1);
        checkOutput("add_result", 16'(res), 16'h100);
        checkOutput("add_timeout", 16'(tmo), 16'd0);
        checkOutput("add_start_cycles", 16'(startCycles), 16'd2);
        checkOutput("add_latency", 16'(latency), 16'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 16'(rsp_valid), 16'd1);
            checkOutput("hold_rsp_result", 16'(rsp_result), 16'h100);
            checkOutput("hold_cmd_ready", 16'(cmd_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("hs_rsp_valid", 16'(rsp_valid), 16'd0);
        checkOutput("hs_cmd_ready", 16'(cmd_ready), 16'd1);

        // AND then XOR with rsp_ready high.
        applyStimulus(8'hF0, 8'h3C, OP_AND, startCycles, latency, res, tmo, seen);
        checkOutput("and_result", 16'(res), 16'h030);
        checkOutput("and_start_cycles", 16'(startCycles), 16'd2);
        @(negedge clk);
        applyStimulus(8'hF0, 8'h3C, OP_XOR, startCycles, latency, res, tmo, seen);
        checkOutput("xor_result", 16'(res), 16'h0CC);
        checkOutput("xor_start_cycles", 16'(startCycles), 16'd2);
        @(negedge clk);

        // NOP: one ISSUE cycle, zero result.
        applyStimulus(8'h12, 8'h34, OP_NOP, startCycles, latency, res, tmo, seen);
        checkOutput("nop_seen", 16'(seen), 16'd1);
        checkOutput("nop_result", 16'(res), 16'h000);
        checkOutput("nop_timeout", 16'(tmo), 16'd0);
        checkOutput("nop_start_cycles", 16'(startCycles), 16'd1);
        @(negedge clk);

        // Timeout with alu_done tied low.
        aluEn = 1'b0;
        applyStimulus(8'h55, 8'hAA, OP_ADD, startCycles, latency, res, tmo, seen);
        checkOutput("tmo_seen", 16'(seen), 16'd1);
        checkOutput("tmo_result", 16'(res), 16'h000);
        checkOutput("tmo_timeout", 16'(tmo), 16'd1);
        checkOutput("tmo_start_cycles", 16'(startCycles), 16'd16);
        @(negedge clk);
        aluEn = 1'b1;

        // alu_done arrives on the last allowed cycle: done wins over timeout.
        aluLat = 15;
        applyStimulus(8'h55, 8'hAA, OP_ADD, startCycles, latency, res, tmo, seen);
        checkOutput("edge_result", 16'(res), 16'h0FF);
        checkOutput("edge_timeout", 16'(tmo), 16'd0);
        checkOutput("edge_start_cycles", 16'(startCycles), 16'd16);
        @(negedge clk);
        aluLat = 1;
`ifdef TINYALU_REQ_STATS_EN
        checkOutput("stat_cmds", stat_cmds, 16'd6);
        checkOutput("stat_timeouts", stat_timeouts, 16'd1);
`endif

        // Reset pulsed while ISSUE is waiting on the ALU.
        aluEn     = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = 8'h01;
        cmd_b     = 8'h02;
        cmd_op    = OP_ADD;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("mid_alu_start", 16'(alu_start), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_alu_start", 16'(alu_start), 16'd0);
        checkOutput("async_cmd_ready", 16'(cmd_ready), 16'd1);
        @(negedge clk);
        reset_n = 1'b1;
        aluEn   = 1'b1;
        quiet   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || alu_start) quiet = 1'b0;
        end
        checkOutput("post_rst_quiet", 16'(quiet), 16'd1);
        applyStimulus(8'h03, 8'h04, OP_ADD, startCycles, latency, res, tmo, seen);
        checkOutput("post_rst_result", 16'(res), 16'h007);
        checkOutput("post_rst_start_cycles", 16'(startCycles), 16'd2);
        @(negedge clk);
`ifdef TINYALU_REQ_STATS_EN
        checkOutput("post_rst_stat_cmds", stat_cmds, 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
